// File: rtl/ram_seq_reader_pkg.sv
// rtl/ram_seq_reader_pkg.sv - shared widths and state encoding for the sequential RAM reader
//
// Purpose: single home for the address/data widths and the reader FSM state type,
// imported by ram_seq_reader.
package ram_seq_reader_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Remaining-word counter needs one extra bit so a full 256-word burst fits.
    localparam int REM_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Burst length as loaded into the remaining counter: 0 encodes 256 words.
    function automatic logic [REM_W-1:0] burst_words(input logic [ADDR_W-1:0] len);
        burst_words = (len == '0) ? REM_W'(1 << ADDR_W) : {1'b0, len};
    endfunction

endpackage

// File: rtl/ram_seq_reader.sv
// rtl/ram_seq_reader.sv - burst reader walking a synchronous RAM and presenting words with a valid/ready handshake
//
// Purpose: on start, reads `length` consecutive words (0 = 256) beginning at
// base_addr from a one-cycle-latency synchronous RAM, wrapping modulo 256, and
// hands each word to a consumer with dout_valid/dout_ready. One word per three
// cycles when the consumer never stalls.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   burst request, honoured only while idle
//   base_addr  in   first RAM address of the burst
//   length     in   word count, 0 means 256
//   mem_addr   out  RAM address (the internal address register)
//   mem_q      in   RAM read data, one edge after mem_addr is sampled
//   dout       out  registered read word
//   dout_addr  out  address dout was read from
//   dout_valid out  dout/dout_addr hold an unaccepted word
//   dout_ready in   consumer accepts when high with dout_valid
//   busy       out  high whenever a burst is in progress
//   done       out  one-cycle pulse after the last word is accepted
module ram_seq_reader
    import ram_seq_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [REM_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_dout;
    logic [ADDR_W-1:0] r_dout_addr;
    logic              r_dout_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_handshake;
    logic              w_last_word;

    assign w_handshake = r_dout_valid && dout_ready;
    assign w_last_word = (r_remaining == REM_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_dout       <= '0;
            r_dout_addr  <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // base_addr/length are captured only here, so later changes
                    // cannot disturb a burst already under way.
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= burst_words(length);
                        r_busy      <= 1'b1;
                        r_state     <= ST_FETCH;
                    end
                end

                // RAM samples mem_addr at the closing edge of FETCH.
                ST_FETCH: begin
                    r_state <= ST_WAIT;
                end

                // mem_q now carries the word for r_addr; latch it with its address.
                ST_WAIT: begin
                    r_dout       <= mem_q;
                    r_dout_addr  <= r_addr;
                    r_dout_valid <= 1'b1;
                    r_state      <= ST_VALID;
                end

                ST_VALID: begin
                    if (w_handshake) begin
                        r_dout_valid <= 1'b0;
                        if (w_last_word) begin
                            r_remaining <= '0;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_addr      <= r_addr + ADDR_W'(1);
                            r_remaining <= r_remaining - REM_W'(1);
                            r_state     <= ST_FETCH;
                        end
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_dout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = r_addr;
    assign dout       = r_dout;
    assign dout_addr  = r_dout_addr;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
